// File: rtl/cbus_axi_bridge_pkg.sv
// Shared cache-bus and AXI channel types used by the cbus-to-AXI bridge.
package cbus_axi_bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [2:0] {
    SIZE_1   = 3'd0,
    SIZE_2   = 3'd1,
    SIZE_4   = 3'd2,
    SIZE_8   = 3'd3,
    SIZE_16  = 3'd4,
    SIZE_32  = 3'd5,
    SIZE_64  = 3'd6,
    SIZE_128 = 3'd7
  } size_t;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    size_t             size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
    burst_t            burst;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

  typedef struct packed {
    logic              ar_valid;
    logic [ID_W-1:0]   ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [LEN_W-1:0]  ar_len;
    size_t             ar_size;
    burst_t            ar_burst;
    logic              aw_valid;
    logic [ID_W-1:0]   aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [LEN_W-1:0]  aw_len;
    size_t             aw_size;
    burst_t            aw_burst;
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              w_last;
    logic              r_ready;
    logic              b_ready;
  } axi_req_t;

  typedef struct packed {
    logic              ar_ready;
    logic              aw_ready;
    logic              w_ready;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              r_valid;
    logic              b_valid;
    logic [1:0]        b_resp;
  } axi_resp_t;

endpackage

// File: rtl/cbus_axi_bridge.sv
// Converts one arbitrated cache-bus request at a time into an AXI read or write burst.
// Handshake: a beat transfers in any cycle where VALID and READY are both high; VALID and payload hold until then.
module cbus_axi_bridge
  import cbus_axi_bridge_pkg::*;
#(
  parameter logic [ID_W-1:0] AXI_ID = 4'b0000
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output axi_req_t   axi_req,
  input  axi_resp_t  axi_resp,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_AW   = 3'd3;
  localparam logic [2:0] ST_W    = 3'd4;
  localparam logic [2:0] ST_B    = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [LEN_W-1:0] beat_cnt;
  logic             w_final;
  logic             unused_resp;

  // Response codes are deliberately dropped; errored transfers complete like good ones.
  assign unused_resp = ^{axi_resp.r_resp, axi_resp.b_resp};
  assign w_final     = (beat_cnt == creq.len);
  assign dbg_state   = state;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (creq.valid) state_next = creq.is_write ? ST_AW : ST_AR;
      ST_AR:   if (axi_resp.ar_ready) state_next = ST_R;
      ST_R:    if (axi_resp.r_valid && axi_resp.r_last) state_next = ST_IDLE;
      ST_AW:   if (axi_resp.aw_ready) state_next = ST_W;
      ST_W:    if (axi_resp.w_ready && w_final) state_next = ST_B;
      ST_B:    if (axi_resp.b_valid) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_AW && axi_resp.aw_ready) begin
        beat_cnt <= '0;
      end else if (state == ST_W && axi_resp.w_ready && !w_final) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Payloads come straight from the held request; only valids/readies depend on state.
  always_comb begin
    axi_req          = '0;
    axi_req.ar_id    = AXI_ID;
    axi_req.ar_addr  = creq.addr;
    axi_req.ar_len   = creq.len;
    axi_req.ar_size  = creq.size;
    axi_req.ar_burst = creq.burst;
    axi_req.aw_id    = AXI_ID;
    axi_req.aw_addr  = creq.addr;
    axi_req.aw_len   = creq.len;
    axi_req.aw_size  = creq.size;
    axi_req.aw_burst = creq.burst;
    axi_req.w_data   = creq.data;
    axi_req.w_strb   = creq.strobe;
    axi_req.ar_valid = (state == ST_AR);
    axi_req.aw_valid = (state == ST_AW);
    axi_req.w_valid  = (state == ST_W);
    axi_req.w_last   = (state == ST_W) && w_final;
    axi_req.r_ready  = (state == ST_R);
    axi_req.b_ready  = (state == ST_B);
  end

  always_comb begin
    cresp = '0;
    case (state)
      ST_R: begin
        cresp.ready = axi_resp.r_valid;
        cresp.last  = axi_resp.r_valid && axi_resp.r_last;
        cresp.data  = axi_resp.r_data;
      end
      ST_W: cresp.ready = axi_resp.w_ready && !w_final;
      ST_B: begin
        cresp.ready = axi_resp.b_valid;
        cresp.last  = axi_resp.b_valid;
      end
      default: cresp = '0;
    endcase
  end

endmodule
